// File: rtl/key_debouncer.sv
// key_debouncer
//   Debounces W_KEY independent push-button inputs. Each key passes through a
//   two-flop synchronizer and a stability counter; a new synced level is
//   accepted only after it has held for CNT_MAX unbroken cycles.
//
// Parameters
//   W_KEY    number of independent keys
//   CNT_MAX  consecutive stable cycles required before acceptance (>= 1)
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous, active-high reset
//   key_raw      raw button levels, asynchronous to clk
//   key_out      debounced level, 1 = pressed
//   key_press    one-cycle pulse on each accepted 0->1 transition
//   key_release  one-cycle pulse on each accepted 1->0 transition
//   key_toggle   flips on every accepted press
//
// Build option
//   KEY_ACTIVE_LOW_EN  when defined, key_raw is inverted ahead of the
//                      synchronizer (raw 0 = pressed, for pull-up buttons).
module key_debouncer #(
    parameter int unsigned W_KEY   = 2,
    parameter int unsigned CNT_MAX = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W_KEY-1:0] key_raw,
    output logic [W_KEY-1:0] key_out,
    output logic [W_KEY-1:0] key_press,
    output logic [W_KEY-1:0] key_release,
    output logic [W_KEY-1:0] key_toggle
);

    localparam int unsigned     CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [W_KEY-1:0] key_in;

`ifdef KEY_ACTIVE_LOW_EN
    assign key_in = ~key_raw;
`else
    assign key_in = key_raw;
`endif

    logic [W_KEY-1:0] sync1_q;
    logic [W_KEY-1:0] sync2_q;
    logic [W_KEY-1:0] out_q,     out_d;
    logic [W_KEY-1:0] press_q,   press_d;
    logic [W_KEY-1:0] release_q, release_d;
    logic [W_KEY-1:0] toggle_q,  toggle_d;
    logic [CNT_W-1:0] cnt_q [W_KEY];
    logic [CNT_W-1:0] cnt_d [W_KEY];

    always_comb begin
        out_d     = out_q;
        press_d   = '0;
        release_d = '0;
        for (int unsigned k = 0; k < W_KEY; k++) begin
            // Counter clears whenever the synced level matches the accepted
            // one, so any glitch back restarts qualification from zero.
            cnt_d[k] = '0;
            if (sync2_q[k] != out_q[k]) begin
                if (cnt_q[k] == CNT_LAST) begin
                    out_d[k]     = sync2_q[k];
                    press_d[k]   = sync2_q[k];
                    release_d[k] = ~sync2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
        end
        toggle_d = toggle_q ^ press_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            out_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            toggle_q  <= '0;
            for (int unsigned k = 0; k < W_KEY; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            sync1_q   <= key_in;
            sync2_q   <= sync1_q;
            out_q     <= out_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
            for (int unsigned k = 0; k < W_KEY; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign key_out     = out_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_toggle  = toggle_q;

endmodule

// File: tb/tb_key_debouncer.sv
module tb_key_debouncer;

    localparam int W   = 2;
    localparam int CNT = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] key_raw;
    logic [W-1:0] key_out, key_press, key_release, key_toggle;

    int total = 0;
    int bad   = 0;

    // Reference model state (logical "pressed" domain)
    logic [W-1:0] m_s1, m_s2, m_out, m_press, m_rel, m_tog;
    logic [W-1:0] hist[$];

    key_debouncer #(.W_KEY(W), .CNT_MAX(CNT)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_raw    (key_raw),
        .key_out    (key_out),
        .key_press  (key_press),
        .key_release(key_release),
        .key_toggle (key_toggle)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] phys(input logic [W-1:0] pressed);
`ifdef KEY_ACTIVE_LOW_EN
        return ~pressed;
`else
        return pressed;
`endif
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_out = '0;
        m_press = '0; m_rel = '0; m_tog = '0;
        hist.delete();
    endtask

    // A level is accepted once the last CNT synced samples all differ
    // from the currently accepted level.
    task automatic model_edge(input logic [W-1:0] pressed);
        logic all_diff;
        hist.push_back(m_s2);
        if (hist.size() > CNT) void'(hist.pop_front());
        m_press = '0;
        m_rel   = '0;
        for (int k = 0; k < W; k++) begin
            if (hist.size() == CNT) begin
                all_diff = 1'b1;
                foreach (hist[j]) if (hist[j][k] == m_out[k]) all_diff = 1'b0;
                if (all_diff) begin
                    m_out[k] = ~m_out[k];
                    if (m_out[k]) m_press[k] = 1'b1;
                    else          m_rel[k]   = 1'b1;
                end
            end
        end
        m_tog = m_tog ^ m_press;
        m_s2  = m_s1;
        m_s1  = pressed;
    endtask

    // Drive a level (called just after a negedge), take one posedge,
    // advance the model, and return at the following negedge.
    task automatic step(input logic [W-1:0] pressed);
        key_raw = phys(pressed);
        @(posedge clk);
        model_edge(pressed);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        key_raw = phys('0);
        model_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({key_out, key_press, key_release, key_toggle} !== '0) begin
            bad++;
            $display("FAIL reset_state got=%b exp=0", {key_out, key_press, key_release, key_toggle});
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step('0);
        total++;
        if ({key_out, key_press, key_release, key_toggle} !== '0) begin
            bad++;
            $display("FAIL idle_after_reset got=%b exp=0", {key_out, key_press, key_release, key_toggle});
        end
    endtask

    task automatic test_clean_press();
        for (int i = 1; i <= 8; i++) begin
            step(2'b01);
            total++;
            if (key_press !== ((i == 6) ? 2'b01 : 2'b00)) begin
                bad++;
                $display("FAIL clean_press edge=%0d got=%b exp=%b", i, key_press, (i == 6) ? 2'b01 : 2'b00);
            end
            total++;
            if (key_out !== ((i >= 6) ? 2'b01 : 2'b00)) begin
                bad++;
                $display("FAIL clean_out edge=%0d got=%b exp=%b", i, key_out, (i >= 6) ? 2'b01 : 2'b00);
            end
        end
        total++;
        if (key_toggle !== 2'b01) begin
            bad++;
            $display("FAIL clean_toggle got=%b exp=01", key_toggle);
        end
    endtask

    task automatic test_bounce();
        logic [W-1:0] pat;
        int pulses;
        do_reset();
        for (int i = 0; i < 6; i++) step('0);
        pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            case (i)
                2, 5:    pat = 2'b00;
                default: pat = 2'b01;
            endcase
            step(pat);
            if (key_press[0]) pulses++;
            total++;
            if (key_press[0] !== (i == 11)) begin
                bad++;
                $display("FAIL bounce_press edge=%0d got=%b exp=%b", i, key_press[0], (i == 11));
            end
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL bounce_pulse_count got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) step(2'b11);
        total++;
        if (key_out !== 2'b11) begin
            bad++;
            $display("FAIL both_pressed got=%b exp=11", key_out);
        end
        for (int i = 1; i <= 8; i++) begin
            step(2'b00);
            total++;
            if (key_release !== ((i == 6) ? 2'b11 : 2'b00) || key_press !== 2'b00) begin
                bad++;
                $display("FAIL dual_release edge=%0d got=%b/%b exp=%b/00", i, key_release, key_press, (i == 6) ? 2'b11 : 2'b00);
            end
        end
        total++;
        if (key_out !== 2'b00) begin
            bad++;
            $display("FAIL dual_release_out got=%b exp=00", key_out);
        end
    endtask

    task automatic test_toggle();
        do_reset();
        for (int n = 1; n <= 2; n++) begin
            for (int i = 0; i < 8; i++) step(2'b01);
            total++;
            if (key_toggle[0] !== ((n == 1) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL toggle press=%0d got=%b exp=%b", n, key_toggle[0], (n == 1));
            end
            for (int i = 0; i < 8; i++) step(2'b00);
        end
    endtask

    task automatic test_reset_midcount();
        do_reset();
        for (int i = 0; i < 8; i++) step(2'b01);
        for (int i = 0; i < 4; i++) step(2'b10);
        #2 rst = 1'b1;
        model_reset();
        #1;
        total++;
        if ({key_out, key_press, key_release, key_toggle} !== '0) begin
            bad++;
            $display("FAIL midcount_reset got=%b exp=0", {key_out, key_press, key_release, key_toggle});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step(2'b10);
            total++;
            if (key_press !== ((i == 6) ? 2'b10 : 2'b00)) begin
                bad++;
                $display("FAIL requalify edge=%0d got=%b exp=%b", i, key_press, (i == 6) ? 2'b10 : 2'b00);
            end
        end
        total++;
        if (key_toggle !== 2'b10) begin
            bad++;
            $display("FAIL requalify_toggle got=%b exp=10", key_toggle);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] lvl;
        int           hold [W];
        lvl = '0;
        for (int k = 0; k < W; k++) hold[k] = 0;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < W; k++) begin
                if (hold[k] == 0) begin
                    lvl[k]  = 1'($urandom_range(0, 1));
                    hold[k] = $urandom_range(1, 9);
                end
                hold[k]--;
            end
            step(lvl);
            total++;
            if (key_out !== m_out || key_press !== m_press || key_release !== m_rel || key_toggle !== m_tog) begin
                bad++;
                $display("FAIL random cyc=%0d got out=%b p=%b r=%b t=%b exp out=%b p=%b r=%b t=%b",
                         c, key_out, key_press, key_release, key_toggle, m_out, m_press, m_rel, m_tog);
            end
            total++;
            if ((key_press & key_release) !== '0) begin
                bad++;
                $display("FAIL press_release_overlap cyc=%0d got=%b exp=00", c, key_press & key_release);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_back_to_back();
        test_toggle();
        test_reset_midcount();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
